fpga_reset_sequencer: RTL and testbench

- Parametrised successor to the fixed 20-cycle power-on reset counter in the FPGA board top level.
- Generates NUM_DOMAINS staged, active-low reset releases from one clock.
- Gates on PLL lock, a debounced board button and a soft-reset request.
- Records the cause of the most recent reset for debug readout over the UART/GPIO pins.

---
 rtl/fpga_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fpga_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_reset_sequencer.sv
// Staged power-on reset sequencer: holds NUM_DOMAINS active-low resets until PLL lock,
// then releases them in index order; aborts on lock loss, button or soft request.
module fpga_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS     = 2,
  parameter int unsigned HOLD_CYCLES     = 20,
  parameter int unsigned STAGE_GAP       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   btn_rst,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   ready,
  output logic [3:0]             reset_cause,
  output logic                   busy
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GW = $clog2(STAGE_GAP + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t                 state, state_d;
  logic [HW-1:0]          hold_cnt, hold_d;
  logic [GW-1:0]          gap_cnt, gap_d;
  logic [NUM_DOMAINS-1:0] rst_n_d;
  logic                   ready_d;
  logic                   busy_d;
  logic [3:0]             cause_d;

  logic          lock_meta, lock_s, lock_q;
  logic          btn_meta, btn_s, btn_db;
  logic [DW-1:0] db_cnt;
  logic          lock_fall, abort;

  // Two-flop synchronisers; lock_q keeps the previous synced lock for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      lock_q    <= 1'b0;
      btn_meta  <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
      lock_q    <= lock_s;
      btn_meta  <= btn_rst;
      btn_s     <= btn_meta;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  assign lock_fall = lock_q & ~lock_s;
  assign abort     = lock_fall | btn_db | soft_rst_req;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ASSERT;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      rst_n_out   <= '0;
      ready       <= 1'b0;
      busy        <= 1'b1;
      reset_cause <= 4'b0001;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      gap_cnt     <= gap_d;
      rst_n_out   <= rst_n_d;
      ready       <= ready_d;
      busy        <= busy_d;
      reset_cause <= cause_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    gap_d   = gap_cnt;
    rst_n_d = rst_n_out;
    ready_d = ready;
    cause_d = reset_cause;
    if (abort) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      gap_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      cause_d = {soft_rst_req, btn_db, lock_fall, 1'b0};
    end else begin
      case (state)
        ST_ASSERT: begin
          rst_n_d = '0;
          ready_d = 1'b0;
          state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES)) begin
            rst_n_d = NUM_DOMAINS'(1);
            gap_d   = '0;
            if (rst_n_d[NUM_DOMAINS-1]) begin
              ready_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
        ST_RELEASE: begin
          // Domains release in order, so each stage shifts one more 1 in from bit 0
          if (gap_cnt == GW'(STAGE_GAP - 1)) begin
            rst_n_d = (rst_n_out << 1) | NUM_DOMAINS'(1);
            gap_d   = '0;
            if (rst_n_d[NUM_DOMAINS-1]) begin
              ready_d = 1'b1;
              state_d = ST_RUN;
            end
          end else begin
            gap_d = gap_cnt + GW'(1);
          end
        end
        ST_RUN: begin
        end
        default: state_d = ST_ASSERT;
      endcase
    end
    busy_d = (state_d != ST_RUN);
  end

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Scoreboard bench: two sequencer configurations driven in lockstep against a
// timing-rule reference model, plus directed latency and cause checks.
module tb_fpga_reset_sequencer;

  localparam int NA = 2, HA = 20, GA = 4, DA = 8;
  localparam int NB = 4, HB = 1,  GB = 1, DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, pll_locked = 1'b0, btn_rst = 1'b0, soft_rst_req = 1'b0;
  logic [NA-1:0] rn_a;
  logic          rdy_a, bsy_a;
  logic [3:0]    cz_a;
  logic [NB-1:0] rn_b;
  logic          rdy_b, bsy_b;
  logic [3:0]    cz_b;

  fpga_reset_sequencer #(.NUM_DOMAINS(NA), .HOLD_CYCLES(HA), .STAGE_GAP(GA), .DEBOUNCE_CYCLES(DA)) dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .btn_rst(btn_rst), .soft_rst_req(soft_rst_req),
    .rst_n_out(rn_a), .ready(rdy_a), .reset_cause(cz_a), .busy(bsy_a));

  fpga_reset_sequencer #(.NUM_DOMAINS(NB), .HOLD_CYCLES(HB), .STAGE_GAP(GB), .DEBOUNCE_CYCLES(DB)) dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .btn_rst(btn_rst), .soft_rst_req(soft_rst_req),
    .rst_n_out(rn_b), .ready(rdy_b), .reset_cause(cz_b), .busy(bsy_b));

  // Model: time of the latest sequence start and of lock acceptance; outputs follow from timing rules
  typedef struct packed {
    int         start_t;
    int         hold_t;
    logic [3:0] cause;
    logic       lk1, lk2, lkp, bt1, bt2, acc;
    int         streak;
  } model_t;

  typedef struct packed {
    logic [7:0] a;
    logic [9:0] b;
  } exp_t;

  model_t ma, mb;
  exp_t   q[$];
  exp_t   mx;
  int     nvec = 0, nfail = 0;
  int     cyc = 0, last_e = 0;
  int     rise_a[NA];
  int     rise_b[NB];

  function automatic model_t step(input model_t m, input int e, input int d,
                                  input logic r, input logic p, input logic b, input logic s);
    model_t n = m;
    logic fall, db;
    fall = m.lkp & ~m.lk2;
    db   = m.acc;
    if (r) begin
      n.start_t = e; n.hold_t = -1; n.cause = 4'b0001;
    end else if (fall || db || s) begin
      n.start_t = e; n.hold_t = -1; n.cause = {s, db, fall, 1'b0};
    end else if (m.hold_t < 0 && e >= m.start_t + 2 && m.lk2) begin
      n.hold_t = e;
    end
    if (r) begin
      n.acc = 1'b0; n.streak = 0;
    end else if (m.bt2 != m.acc) begin
      if (m.streak + 1 >= d) begin n.acc = m.bt2; n.streak = 0; end
      else n.streak = m.streak + 1;
    end else begin
      n.streak = 0;
    end
    n.lkp = r ? 1'b0 : m.lk2;
    n.lk2 = r ? 1'b0 : m.lk1;
    n.lk1 = r ? 1'b0 : p;
    n.bt2 = r ? 1'b0 : m.bt1;
    n.bt1 = r ? 1'b0 : b;
    return n;
  endfunction

  // Domain k is released hold+1+k*gap edges after lock was accepted
  function automatic logic [7:0] exp_rn(input model_t m, input int e, input int n, input int h, input int g);
    logic [7:0] v = '0;
    for (int k = 0; k < n; k++)
      if (m.hold_t >= 0 && e >= m.hold_t + h + 1 + k * g) v[k] = 1'b1;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic tick(input logic r, input logic p, input logic b, input logic s);
    logic [7:0] va, vb;
    exp_t x;
    rst = r; pll_locked = p; btn_rst = b; soft_rst_req = s;
    @(posedge clk);
    last_e = cyc;
    ma = step(ma, cyc, DA, r, p, b, s);
    mb = step(mb, cyc, DB, r, p, b, s);
    va = exp_rn(ma, cyc, NA, HA, GA);
    vb = exp_rn(mb, cyc, NB, HB, GB);
    x.a = {va[NA-1:0], va[NA-1], ma.cause, ~va[NA-1]};
    x.b = {vb[NB-1:0], vb[NB-1], mb.cause, ~vb[NB-1]};
    q.push_back(x);
    cyc++;
    #1;
  endtask

  task automatic clear_rises();
    for (int k = 0; k < NA; k++) rise_a[k] = -1;
    for (int k = 0; k < NB; k++) rise_b[k] = -1;
  endtask

  task automatic note_rises();
    for (int k = 0; k < NA; k++) if (rn_a[k] && rise_a[k] < 0) rise_a[k] = last_e;
    for (int k = 0; k < NB; k++) if (rn_b[k] && rise_b[k] < 0) rise_b[k] = last_e;
  endtask

  // Monitor: one expected bundle per clock, compared on the falling edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mx = q.pop_front();
      nvec++;
      if ({rn_a, rdy_a, cz_a, bsy_a} !== mx.a) begin
        nfail++;
        $display("FAIL cfg_a cyc %0d: got %h, want %h", cyc, {rn_a, rdy_a, cz_a, bsy_a}, mx.a);
      end
      nvec++;
      if ({rn_b, rdy_b, cz_b, bsy_b} !== mx.b) begin
        nfail++;
        $display("FAIL cfg_b cyc %0d: got %h, want %h", cyc, {rn_b, rdy_b, cz_b, bsy_b}, mx.b);
      end
    end
  end

  initial begin
    int e0, p0, pl_left, bt_left;
    logic pl, bl, rr, ss;
    ma = '0; ma.hold_t = -1; ma.cause = 4'b0001;
    mb = ma;

    // Power-on with lock already present
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    e0 = cyc;
    clear_rises();
    for (int i = 0; i < 40; i++) begin tick(1'b0, 1'b1, 1'b0, 1'b0); note_rises(); end
    check("a dom0 rise", rise_a[0], e0 + 23);
    check("a dom1 rise", rise_a[1], e0 + 27);
    for (int k = 0; k < NB; k++) check($sformatf("b dom%0d rise", k), rise_b[k], e0 + 4 + k);
    check("a ready", int'(rdy_a), 1);
    check("a busy", int'(bsy_a), 0);
    check("a cause por", int'(cz_a), 1);

    // Late lock
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    clear_rises();
    for (int i = 0; i < 50; i++) begin tick(1'b0, 1'b0, 1'b0, 1'b0); note_rises(); end
    check("a held before lock", int'(rn_a), 0);
    p0 = cyc;
    for (int i = 0; i < 40; i++) begin tick(1'b0, 1'b1, 1'b0, 1'b0); note_rises(); end
    check("a late lock rise", rise_a[0], p0 + 23);

    // One-cycle lock loss while running
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("a lock loss outputs", int'(rn_a), 0);
    check("a cause lock loss", int'(cz_a), 2);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Short button pulse is filtered, long press resets
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("a pulse ignored", int'(rdy_a), 1);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("a press outputs", int'(rn_a), 0);
    check("b cause button", int'(cz_b), 4);
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Soft reset between domain releases
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    e0 = cyc;
    while (last_e < e0 + 25) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("a dom0 only", int'(rn_a), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    check("a soft outputs", int'(rn_a), 0);
    check("a cause soft", int'(cz_a), 8);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic
    pl = 1'b1; bl = 1'b0; pl_left = 100; bt_left = 50;
    for (int i = 0; i < 3000; i++) begin
      if (pl_left == 0) begin
        pl = ~pl;
        pl_left = pl ? int'($urandom_range(20, 200)) : int'($urandom_range(1, 5));
      end
      if (bt_left == 0) begin
        bl = ~bl;
        bt_left = bl ? int'($urandom_range(1, 15)) : int'($urandom_range(20, 150));
      end
      pl_left--; bt_left--;
      rr = ($urandom_range(0, 799) == 0);
      ss = ($urandom_range(0, 149) == 0);
      tick(rr, pl, bl, ss);
    end

    @(negedge clk);
    #1;
    check("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
